// File: rtl/mips_pkg.sv
// mips_pkg: shared MIPS encodings for the multiply/divide unit.
// Holds the op codes, the multiply/divide FSM states and the iteration count.
package mips_pkg;
  localparam int DIV_ITER = 32;
  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;
  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    CALC   = 2'b01,
    FINISH = 2'b10
  } state_e;
endpackage

// File: rtl/mult_div_unit_en_reg.sv
// mult_div_unit_en_reg: enable register used for the architectural HI and LO.
// Ports: clock, reset (async active-low), en (load strobe), d (data in), q (stored value).
module mult_div_unit_en_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge clock or negedge reset)
    if (!reset) q <= '0;
    else if (en) q <= d;
endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, one bit per cycle.
// Ports: clock, reset (async active-low); start/op/operand_a/operand_b issue an operation;
// flush abandons it; mthi_en/mtlo_en/move_data perform MTHI/MTLO; busy, done, hi, lo are outputs.
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             flush,
  input  logic             mthi_en,
  input  logic             mtlo_en,
  input  logic [WIDTH-1:0] move_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(DIV_ITER);
  state_e state, state_nxt;
  logic [CW-1:0] count;
  logic [2*WIDTH-1:0] acc, prod_fix;
  logic [WIDTH:0] rem, b_mag, a_mag, b_mag_in, t, sum;
  logic [WIDTH-1:0] quo_fix, rem_fix, hi_res, lo_res;
  logic is_div, q_neg, r_neg, sgn, ge, fin_wr, mt_ok, accept;
  // Magnitudes carry one extra bit so abs(most negative) is exact.
  assign sgn      = ~op[0];
  assign a_mag    = (sgn & operand_a[WIDTH-1]) ? -{operand_a[WIDTH-1], operand_a} : {1'b0, operand_a};
  assign b_mag_in = (sgn & operand_b[WIDTH-1]) ? -{operand_b[WIDTH-1], operand_b} : {1'b0, operand_b};
  // Divide: shift next dividend bit into the partial remainder, subtract if it fits.
  assign t   = {rem[WIDTH-1:0], acc[WIDTH-1]};
  assign ge  = t >= b_mag;
  // Multiply: add multiplicand into the upper half when the current multiplier bit is set, then shift right.
  assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? b_mag : '0);
  assign prod_fix = q_neg ? -acc : acc;
  // A zero divisor yields an all-ones quotient; the remainder already equals the dividend.
  assign quo_fix  = (b_mag == '0) ? '1 : (q_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]);
  assign rem_fix  = WIDTH'(r_neg ? -rem : rem);
  assign hi_res   = is_div ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
  assign lo_res   = is_div ? quo_fix : prod_fix[WIDTH-1:0];
  assign busy     = state != IDLE;
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nxt;
  // FINISH spans two cycles: the first writes HI/LO and raises done, the second returns to IDLE.
  always_comb begin
    state_nxt = state;
    accept    = state == IDLE && start && !flush;
    fin_wr    = state == FINISH && !done && !flush;
    mt_ok     = state == IDLE && !start;
    if (flush) state_nxt = IDLE;
    else if (accept) state_nxt = CALC;
    else if (state == CALC && count == CW'(DIV_ITER - 1)) state_nxt = FINISH;
    else if (state == FINISH && done) state_nxt = IDLE;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      done   <= 1'b0;
      count  <= '0;
      acc    <= '0;
      rem    <= '0;
      b_mag  <= '0;
      is_div <= 1'b0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
    end else begin
      done <= fin_wr;
      if (accept) begin
        is_div <= op[1];
        q_neg  <= sgn & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
        r_neg  <= sgn & operand_a[WIDTH-1];
        b_mag  <= b_mag_in;
        acc    <= {{WIDTH{1'b0}}, WIDTH'(a_mag)};
        rem    <= '0;
        count  <= '0;
      end else if (state == CALC) begin
        count <= count + 1'b1;
        if (is_div) begin
          rem <= ge ? t - b_mag : t;
          acc <= {acc[2*WIDTH-1:WIDTH], acc[WIDTH-2:0], ge};
        end else acc <= {sum, acc[WIDTH-1:1]};
      end
    end
  mult_div_unit_en_reg #(.WIDTH(WIDTH)) u_hi (
    .clock(clock),
    .reset(reset),
    .en(fin_wr | (mt_ok & mthi_en)),
    .d(fin_wr ? hi_res : move_data),
    .q(hi)
  );
  mult_div_unit_en_reg #(.WIDTH(WIDTH)) u_lo (
    .clock(clock),
    .reset(reset),
    .en(fin_wr | (mt_ok & mtlo_en)),
    .d(fin_wr ? lo_res : move_data),
    .q(lo)
  );
endmodule
